// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared types and constants for the mouse_tracker block:
//   - state_t      : position-update FSM states
//   - BTN_*        : bit positions inside the {middle, right, left} button vector
//   - COL_B*/ROW_B*: TicTacToe 3x3 grid boundaries on a 640x480 screen
//   - DELTA_W/MAX  : width and saturation limit of the coalesced delta sums
//   - sat_add      : saturating add used when packets are coalesced
//   - col_of/row_of: grid cell lookup helpers
// -----------------------------------------------------------------------------
package mouse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_CLAMP,
    S_COMMIT
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  localparam int COL_B1 = 213;
  localparam int COL_B2 = 426;
  localparam int ROW_B1 = 160;
  localparam int ROW_B2 = 320;

  // Deltas are carried as 11-bit signed values so two 9-bit packets can be
  // summed without wrapping; the sum saturates at +/-1023.
  localparam int DELTA_W   = 11;
  localparam int DELTA_MAX = 1023;

  function automatic logic signed [DELTA_W-1:0] sat_add(
    input logic signed [DELTA_W-1:0] a,
    input logic signed [DELTA_W-1:0] b
  );
    logic signed [DELTA_W:0] s;
    s = {a[DELTA_W-1], a} + {b[DELTA_W-1], b};
    if (s > (DELTA_W+1)'(DELTA_MAX))
      return DELTA_W'(DELTA_MAX);
    else if (s < -(DELTA_W+1)'(DELTA_MAX))
      return -DELTA_W'(DELTA_MAX);
    else
      return s[DELTA_W-1:0];
  endfunction

  function automatic logic [1:0] col_of(input int unsigned x);
    if (x < COL_B1)      return 2'd0;
    else if (x < COL_B2) return 2'd1;
    else                 return 2'd2;
  endfunction

  function automatic logic [1:0] row_of(input int unsigned y);
    if (y < ROW_B1)      return 2'd0;
    else if (y < ROW_B2) return 2'd1;
    else                 return 2'd2;
  endfunction

endpackage

// File: rtl/axis_clamp.sv
// -----------------------------------------------------------------------------
// axis_clamp
// Combinational clamp of a signed candidate coordinate into [0, MAX].
// Ports:
//   sum     in  W+5  signed candidate position (old position plus scaled delta)
//   clamped out W    position limited to 0..MAX
// -----------------------------------------------------------------------------
module axis_clamp #(
  parameter int W   = 10,
  parameter int MAX = 639
) (
  input  logic signed [W+4:0] sum,
  output logic        [W-1:0] clamped
);

  localparam logic signed [W+4:0] MAX_S = (W+5)'(MAX);
  localparam logic        [W-1:0] MAX_U = W'(MAX);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    clamped = sum[W-1:0];
    if (sum < 0)
      clamped = '0;
    else if (sum > MAX_S)
      clamped = MAX_U;
  end

endmodule

// File: rtl/mouse_tracker.sv
// -----------------------------------------------------------------------------
// mouse_tracker
// Accumulates decoded PS/2 mouse packets into a clamped, optionally scaled
// screen position and derives button press/release pulses. Packets arriving
// while an update is in progress are coalesced into a one-deep buffer.
//
// Optional feature macro: GRID_EN (3x3 TicTacToe cell lookup and cell_click).
//
// Ports:
//   clk          in   1    system clock
//   reset        in   1    synchronous, active-high reset
//   m_done_tick  in   1    packet strobe; xm/ym/btnm valid this cycle
//   xm, ym       in   9    two's-complement deltas (ym positive = up)
//   btnm         in   3    buttons {middle, right, left}
//   pos_x/pos_y  out  X_W/Y_W  current position
//   pos_valid    out  1    one-cycle pulse when position/buttons update
//   btn_state    out  3    registered button levels
//   btn_press    out  3    rising-edge pulses, aligned with pos_valid
//   btn_release  out  3    falling-edge pulses, aligned with pos_valid
//   cell_col/row out  2    grid cell of the position (0 without GRID_EN)
//   cell_click   out  1    left press, aligned with pos_valid (0 without GRID_EN)
// -----------------------------------------------------------------------------
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int SHIFT    = 0,
  parameter bit Y_INVERT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           m_done_tick,
  input  logic [8:0]     xm,
  input  logic [8:0]     ym,
  input  logic [2:0]     btnm,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           pos_valid,
  output logic [2:0]     btn_state,
  output logic [2:0]     btn_press,
  output logic [2:0]     btn_release,
  output logic [1:0]     cell_col,
  output logic [1:0]     cell_row,
  output logic           cell_click
);

  state_t state, state_next;

  logic signed [DELTA_W-1:0] tick_dx, tick_dy;
  logic signed [DELTA_W-1:0] work_dx, work_dy;
  logic        [2:0]         work_btn;
  logic                      pend_full;
  logic signed [DELTA_W-1:0] pend_dx, pend_dy;
  logic        [2:0]         pend_btn;

  logic signed [X_W+4:0] dx_ext, sum_x;
  logic signed [Y_W+4:0] dy_ext, sum_y;
  logic signed [X_W+4:0] px_ext;
  logic signed [Y_W+4:0] py_ext;
  logic        [X_W-1:0] clamp_x;
  logic        [Y_W-1:0] clamp_y;

  assign tick_dx = {{(DELTA_W-9){xm[8]}}, xm};
  assign tick_dy = {{(DELTA_W-9){ym[8]}}, ym};

  // Size casts of signed operands sign-extend.
  assign dx_ext = (X_W+5)'(work_dx) <<< SHIFT;
  assign dy_ext = (Y_W+5)'(work_dy) <<< SHIFT;
  assign px_ext = $signed({5'b0, pos_x});
  assign py_ext = $signed({5'b0, pos_y});

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (m_done_tick) state_next = S_CALC;
      S_CALC:   state_next = S_CLAMP;
      S_CLAMP:  state_next = S_COMMIT;
      // A tick landing in COMMIT with an empty buffer is taken straight into
      // the work registers; parking it in the buffer would strand it in IDLE.
      S_COMMIT: state_next = (pend_full || m_done_tick) ? S_CALC : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Work registers and coalescing buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      work_dx   <= '0;
      work_dy   <= '0;
      work_btn  <= '0;
      pend_full <= 1'b0;
      pend_dx   <= '0;
      pend_dy   <= '0;
      pend_btn  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (m_done_tick) begin
            work_dx  <= tick_dx;
            work_dy  <= tick_dy;
            work_btn <= btnm;
          end
        end
        S_COMMIT: begin
          if (pend_full) begin
            work_dx  <= pend_dx;
            work_dy  <= pend_dy;
            work_btn <= pend_btn;
            if (m_done_tick) begin
              pend_dx  <= tick_dx;
              pend_dy  <= tick_dy;
              pend_btn <= btnm;
            end else begin
              pend_full <= 1'b0;
            end
          end else if (m_done_tick) begin
            work_dx  <= tick_dx;
            work_dy  <= tick_dy;
            work_btn <= btnm;
          end
        end
        default: begin
          if (m_done_tick) begin
            pend_full <= 1'b1;
            pend_btn  <= btnm;
            if (pend_full) begin
              pend_dx <= sat_add(pend_dx, tick_dx);
              pend_dy <= sat_add(pend_dy, tick_dy);
            end else begin
              pend_dx <= tick_dx;
              pend_dy <= tick_dy;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: sums in CALC, clamp in CLAMP; the edge leaving CLAMP loads the
  // outputs so they are visible with pos_valid during COMMIT.
  // ---------------------------------------------------------------------------
  axis_clamp #(.W(X_W), .MAX(X_MAX)) u_clamp_x (.sum(sum_x), .clamped(clamp_x));
  axis_clamp #(.W(Y_W), .MAX(Y_MAX)) u_clamp_y (.sum(sum_y), .clamped(clamp_y));

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_x       <= '0;
      sum_y       <= '0;
      pos_x       <= X_W'(X_INIT);
      pos_y       <= Y_W'(Y_INIT);
      pos_valid   <= 1'b0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      pos_valid   <= 1'b0;
      btn_press   <= '0;
      btn_release <= '0;
      if (state == S_CALC) begin
        sum_x <= px_ext + dx_ext;
        sum_y <= Y_INVERT ? (py_ext - dy_ext) : (py_ext + dy_ext);
      end
      if (state == S_CLAMP) begin
        pos_x       <= clamp_x;
        pos_y       <= clamp_y;
        btn_state   <= work_btn;
        btn_press   <= work_btn & ~btn_state;
        btn_release <= ~work_btn & btn_state;
        pos_valid   <= 1'b1;
      end
    end
  end

`ifdef GRID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_col   <= col_of(X_INIT);
      cell_row   <= row_of(Y_INIT);
      cell_click <= 1'b0;
    end else begin
      cell_click <= 1'b0;
      if (state == S_CLAMP) begin
        cell_col   <= col_of(int'(clamp_x));
        cell_row   <= row_of(int'(clamp_y));
        cell_click <= work_btn[BTN_L] & ~btn_state[BTN_L];
      end
    end
  end
`else
  assign cell_col   = 2'd0;
  assign cell_row   = 2'd0;
  assign cell_click = 1'b0;
`endif

endmodule

// File: tb/tb_mouse_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_tracker
// Directed self-checking bench for mouse_tracker. Four instances share the
// stimulus: u_a (defaults), u_b (start 2,2), u_c (start 635,477) and
// u_d (SHIFT=2, Y_INVERT=0). Honours GRID_EN for the cell outputs.
// -----------------------------------------------------------------------------
module tb_mouse_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_done_tick = 1'b0;
  logic [8:0] xm = '0;
  logic [8:0] ym = '0;
  logic [2:0] btnm = '0;

  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic       pos_valid;
  logic [2:0] btn_state, btn_press, btn_release;
  logic [1:0] cell_col, cell_row;
  logic       cell_click;

  logic [9:0] px [1:3];
  logic [8:0] py [1:3];
  logic       pv [1:3];
  logic [2:0] bs [1:3];
  logic [2:0] bp [1:3];
  logic [2:0] br [1:3];
  logic [1:0] cc [1:3];
  logic [1:0] cr [1:3];
  logic       ck [1:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mouse_tracker u_a (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick),
    .xm(xm), .ym(ym), .btnm(btnm),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .cell_col(cell_col), .cell_row(cell_row), .cell_click(cell_click)
  );

  mouse_tracker #(.X_INIT(2), .Y_INIT(2)) u_b (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick),
    .xm(xm), .ym(ym), .btnm(btnm),
    .pos_x(px[1]), .pos_y(py[1]), .pos_valid(pv[1]),
    .btn_state(bs[1]), .btn_press(bp[1]), .btn_release(br[1]),
    .cell_col(cc[1]), .cell_row(cr[1]), .cell_click(ck[1])
  );

  mouse_tracker #(.X_INIT(635), .Y_INIT(477)) u_c (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick),
    .xm(xm), .ym(ym), .btnm(btnm),
    .pos_x(px[2]), .pos_y(py[2]), .pos_valid(pv[2]),
    .btn_state(bs[2]), .btn_press(bp[2]), .btn_release(br[2]),
    .cell_col(cc[2]), .cell_row(cr[2]), .cell_click(ck[2])
  );

  mouse_tracker #(.SHIFT(2), .Y_INVERT(1'b0)) u_d (
    .clk(clk), .reset(reset), .m_done_tick(m_done_tick),
    .xm(xm), .ym(ym), .btnm(btnm),
    .pos_x(px[3]), .pos_y(py[3]), .pos_valid(pv[3]),
    .btn_state(bs[3]), .btn_press(bp[3]), .btn_release(br[3]),
    .cell_col(cc[3]), .cell_row(cr[3]), .cell_click(ck[3])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_done_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One-cycle packet strobe; returns in the cycle after the tick.
  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    xm = x;
    ym = y;
    btnm = b;
    m_done_tick = 1'b1;
    step();
    m_done_tick = 1'b0;
  endtask

  int pulses;
  logic [2:0] btn_seq   [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
  logic [2:0] press_exp [4] = '{3'b000, 3'b001, 3'b000, 3'b000};
  logic [2:0] rel_exp   [4] = '{3'b000, 3'b000, 3'b000, 3'b001};

  initial begin
    #1;
    // Reset state
    do_reset();
    check("reset_pos_x", pos_x, 320);
    check("reset_pos_y", pos_y, 240);
    check("reset_valid", pos_valid, 0);
    check("reset_btn_state", btn_state, 0);
`ifdef GRID_EN
    check("reset_cell_col", cell_col, 1);
    check("reset_cell_row", cell_row, 1);
`else
    check("reset_cell_col", cell_col, 0);
    check("reset_cell_row", cell_row, 0);
`endif

    // Basic move with fixed latency: tick in N, valid in N+3
    send(9'd5, 9'd3, 3'b000);
    check("lat_valid_n1", pos_valid, 0);
    step();
    check("lat_valid_n2", pos_valid, 0);
    check("lat_pos_x_n2", pos_x, 320);
    step();
    check("lat_valid_n3", pos_valid, 1);
    check("move_pos_x", pos_x, 325);
    check("move_pos_y", pos_y, 237);
    step();
    check("lat_valid_n4", pos_valid, 0);

    // Scaling and Y sense: +3,+3 with SHIFT=2, Y_INVERT=0 on u_d
    do_reset();
    send(9'd3, 9'd3, 3'b000);
    step();
    step();
    check("shift_pos_x", px[3], 332);
    check("noinv_pos_y", py[3], 252);
    check("shift_valid", pv[3], 1);
    check("plain_pos_x", pos_x, 323);
    check("plain_pos_y", pos_y, 237);

    // Clamp at zero (u_b from 2,2): -10,-10 -> (0,12)
    do_reset();
    send(9'h1F6, 9'h1F6, 3'b000);
    step();
    step();
    check("clamp_lo_x", px[1], 0);
    check("clamp_lo_y", py[1], 12);
    check("clamp_lo_valid", pv[1], 1);

    // Clamp at max (u_c from 635,477): +20,-20 -> (639,479)
    do_reset();
    send(9'd20, 9'h1EC, 3'b000);
    step();
    step();
    check("clamp_hi_x", px[2], 639);
    check("clamp_hi_y", py[2], 479);

    // Three back-to-back ticks of +1: two commits, nothing lost
    do_reset();
    xm = 9'd1;
    ym = 9'd0;
    btnm = 3'b000;
    m_done_tick = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pos_valid) pulses++;
    end
    m_done_tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pos_valid) pulses++;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_pos_x", pos_x, 323);
    check("b2b_pos_y", pos_y, 240);

    // Button edges on isolated ticks
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(9'd0, 9'd0, btn_seq[i]);
      step();
      step();
      check($sformatf("btn_valid_%0d", i), pos_valid, 1);
      check($sformatf("btn_press_%0d", i), btn_press, press_exp[i]);
      check($sformatf("btn_release_%0d", i), btn_release, rel_exp[i]);
      check($sformatf("btn_state_%0d", i), btn_state, btn_seq[i]);
      step();
      check($sformatf("btn_press_clr_%0d", i), btn_press, 0);
      step();
    end

    // Grid lookup: move to (300,400), then left press
    do_reset();
    send(9'h1EC, 9'h160, 3'b000);
    step();
    step();
    check("grid_pos_x", pos_x, 300);
    check("grid_pos_y", pos_y, 400);
    step();
    step();
    send(9'd0, 9'd0, 3'b001);
    step();
    step();
`ifdef GRID_EN
    check("grid_col", cell_col, 1);
    check("grid_row", cell_row, 2);
    check("grid_click", cell_click, 1);
`else
    check("grid_col", cell_col, 0);
    check("grid_row", cell_row, 0);
    check("grid_click", cell_click, 0);
`endif
    step();
    check("grid_click_clr", cell_click, 0);
    step();

    // Reset during CALC discards the packet
    do_reset();
    send(9'd5, 9'd3, 3'b001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_pos_x", pos_x, 320);
    check("midrst_pos_y", pos_y, 240);
    check("midrst_valid", pos_valid, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pos_valid) pulses++;
    end
    check("midrst_no_commit", pulses, 0);
    check("midrst_btn_state", btn_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
